// File: rtl/l2_noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_noc_pkg
// Purpose  : Shared NoC flit field positions, assembler states and message
//            type codes for the L2 message-level interface.
// Revision : 1.0 - initial release
// ============================================================================
package l2_noc_pkg;

    // Header flit fields
    localparam int LEN_HI  = 29;
    localparam int LEN_LO  = 22;
    localparam int TYPE_HI = 21;
    localparam int TYPE_LO = 14;

    // Source flit fields (low bit of x and y coordinates)
    localparam int SRCX_LO = 42;
    localparam int SRCY_LO = 34;

    localparam int LEN_W  = 8;
    localparam int TYPE_W = 8;
    localparam int TAG_W  = 26;
    localparam int DATA_W = 64;

    // Assembler states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_SRC   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    // Message type codes seen on the L2 NoC inputs
    localparam logic [TYPE_W-1:0] MSG_TYPE_LOAD_REQ   = 8'd31;
    localparam logic [TYPE_W-1:0] MSG_TYPE_STORE_REQ  = 8'd2;
    localparam logic [TYPE_W-1:0] MSG_TYPE_INV_FWDACK = 8'd20;
    localparam logic [TYPE_W-1:0] MSG_TYPE_STORE_ACK  = 8'd21;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] f);
        return f[LEN_HI:LEN_LO];
    endfunction

    function automatic logic [TYPE_W-1:0] hdr_type(input logic [DATA_W-1:0] f);
        return f[TYPE_HI:TYPE_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_noc_msg_assembler.sv
`default_nettype none
// ============================================================================
// Module   : l2_noc_msg_assembler
// Purpose  : Reassembles a 64-bit NoC flit stream into one message
//            (type, source, tag, first data word) on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module l2_noc_msg_assembler
    import l2_noc_pkg::*;
#(
    parameter int FLIT_W      = 64,
    parameter int TAG_LSB     = 14,
    parameter int SRC_XY_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        flit_in,
    input  logic                     flit_valid,
    output logic                     flit_ready,
    output logic                     msg_valid,
    input  logic                     msg_ready,
    output logic [TYPE_W-1:0]        msg_type,
    output logic [2*SRC_XY_BITS-1:0] msg_source,
    output logic [TAG_W-1:0]         msg_tag,
    output logic [DATA_W-1:0]        msg_data,
    output logic                     err_pulse,
    output logic [15:0]              msg_count
);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic [LEN_W-1:0] w_rem_dec;
    logic             w_accept;
    logic             w_err_set;
    logic             w_lat_type;
    logic             w_lat_tag;
    logic             w_lat_src;
    logic             w_lat_data;
    logic             w_clr_data;
    logic             w_deliver;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_err_set   = 1'b0;
        w_lat_type  = 1'b0;
        w_lat_tag   = 1'b0;
        w_lat_src   = 1'b0;
        w_lat_data  = 1'b0;
        w_clr_data  = 1'b0;
        w_deliver   = 1'b0;
        flit_ready  = (r_state != S_OUT);
        w_accept    = flit_valid && flit_ready;
        // Saturating decrement keeps rem from wrapping below zero
        w_rem_dec   = (r_rem != '0) ? r_rem - 8'd1 : '0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_lat_type = 1'b1;
                    w_rem_nxt  = hdr_len(flit_in[DATA_W-1:0]);
                    if (hdr_len(flit_in[DATA_W-1:0]) == '0) w_err_set = 1'b1;
                    else                                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_accept) begin
                    w_lat_tag = 1'b1;
                    w_rem_nxt = w_rem_dec;
                    if (w_rem_dec == '0) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_SRC;
                    end
                end
            end
            S_SRC: begin
                if (w_accept) begin
                    w_lat_src = 1'b1;
                    w_rem_nxt = w_rem_dec;
                    if (w_rem_dec == '0) begin
                        w_clr_data  = 1'b1;
                        w_state_nxt = S_OUT;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_lat_data  = 1'b1;
                    w_rem_nxt   = w_rem_dec;
                    w_state_nxt = (w_rem_dec == '0) ? S_OUT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_accept) begin
                    w_rem_nxt = w_rem_dec;
                    if (w_rem_dec == '0) w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (msg_ready) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign msg_valid = (r_state == S_OUT);

    // Message fields only change while receiving, so they hold during OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_type   <= '0;
            msg_tag    <= '0;
            msg_source <= '0;
            msg_data   <= '0;
            err_pulse  <= 1'b0;
            msg_count  <= '0;
        end else begin
            err_pulse <= w_err_set;
            if (w_lat_type) msg_type <= hdr_type(flit_in[DATA_W-1:0]);
            if (w_lat_tag)  msg_tag  <= flit_in[TAG_LSB+TAG_W-1:TAG_LSB];
            if (w_lat_src)
                msg_source <= {flit_in[SRCY_LO+SRC_XY_BITS-1:SRCY_LO],
                               flit_in[SRCX_LO+SRC_XY_BITS-1:SRCX_LO]};
            if (w_clr_data)      msg_data <= '0;
            else if (w_lat_data) msg_data <= flit_in[DATA_W-1:0];
            if (w_deliver && (msg_count != 16'hFFFF)) msg_count <= msg_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l2_noc_msg_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_noc_msg_assembler
// Purpose  : Directed, self-checking bench with a packet-level reference model
//            for l2_noc_msg_assembler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_noc_msg_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] flit_in;
    logic        flit_valid;
    logic        flit_ready;
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_type;
    logic [5:0]  msg_source;
    logic [25:0] msg_tag;
    logic [63:0] msg_data;
    logic        err_pulse;
    logic [15:0] msg_count;

    int total = 0;
    int bad   = 0;

    l2_noc_msg_assembler #(.FLIT_W(64), .TAG_LSB(14), .SRC_XY_BITS(3)) dut (
        .clk(clk), .rst(rst),
        .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_type(msg_type), .msg_source(msg_source), .msg_tag(msg_tag),
        .msg_data(msg_data), .err_pulse(err_pulse), .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [7:0] len, input logic [7:0] typ);
        return {34'h0, len, typ, 14'h0};
    endfunction

    function automatic logic [63:0] mk_src(input logic [7:0] x, input logic [7:0] y);
        return {14'h1ABC, x, y, 34'h0};
    endfunction

    // ---------------- packet-level reference model ----------------
    logic [63:0] c_pkt[$];
    bit          m_started = 0;
    bit          m_valid   = 0;
    bit          m_err     = 0;
    logic [15:0] m_count   = '0;
    logic [7:0]  m_type;
    logic [25:0] m_tag;
    logic [5:0]  m_src;
    logic [63:0] m_data;

    task automatic model_take(input logic [63:0] f);
        int len;
        c_pkt.push_back(f);
        len = int'(c_pkt[0][29:22]);
        if (len < 2 && c_pkt.size() == len + 1) begin
            m_err = 1;
            c_pkt.delete();
        end else if (len >= 2 && c_pkt.size() == len + 1) begin
            m_type  = c_pkt[0][21:14];
            m_tag   = c_pkt[1][39:14];
            m_src   = {c_pkt[2][36:34], c_pkt[2][44:42]};
            m_data  = (len >= 3) ? c_pkt[3] : 64'h0;
            m_valid = 1;
            c_pkt.delete();
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            c_pkt.delete();
            m_started = 1;
            m_valid   = 0;
            m_err     = 0;
            m_count   = '0;
        end else begin
            m_err = 0;
            if (m_valid) begin
                if (msg_ready) begin
                    m_valid = 0;
                    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                end
            end else if (flit_valid) begin
                model_take(flit_in);
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("msg_valid", msg_valid, m_valid);
            chk("flit_ready", flit_ready, !m_valid);
            chk("err_pulse", err_pulse, m_err);
            chk("msg_count", msg_count, m_count);
            if (m_valid) begin
                chk("msg_type", msg_type, m_type);
                chk("msg_tag", msg_tag, m_tag);
                chk("msg_source", msg_source, m_src);
                chk("msg_data", msg_data, m_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_flit(input logic [63:0] f);
        bit ok = 0;
        bit rdy;
        flit_in    = f;
        flit_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            rdy = flit_ready;
            @(posedge clk);
            if (rdy) ok = 1;
            #1;
        end
        if (!ok) chk("flit_accept_timeout", 0, 1);
    endtask

    task automatic send_pkt(input logic [63:0] flits[$]);
        foreach (flits[i]) send_flit(flits[i]);
        flit_valid = 1'b0;
    endtask

    task automatic expect_msg(input string nm, input logic [7:0] t, input logic [25:0] tg,
                              input logic [5:0] s, input logic [63:0] d);
        int n = 0;
        @(negedge clk);
        while (!msg_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, msg_valid, 1);
        chk({nm, "_type"}, msg_type, t);
        chk({nm, "_tag"}, msg_tag, tg);
        chk({nm, "_source"}, msg_source, s);
        chk({nm, "_data"}, msg_data, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        flit_valid = 1'b0;
        flit_in    = '0;
        msg_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_msg_valid", msg_valid, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_count", msg_count, 0);
        chk("rst_type", msg_type, 0);
        chk("rst_data", msg_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // L=3 packet with one data word
        send_pkt('{mk_hdr(8'd3, 8'h12), 64'h00_ABCD_4000, mk_src(8'd5, 8'd2),
                   64'hDEADBEEF_00000001});
        expect_msg("p1", 8'h12, 26'h2AF35, 6'b010101, 64'hDEADBEEF_00000001);
        @(negedge clk);
        chk("p1_count", msg_count, 1);
        @(posedge clk); #1;

        // L=2: no data word
        send_pkt('{mk_hdr(8'd2, 8'h34), 64'h12_3456_7FFF, mk_src(8'd7, 8'd0)});
        expect_msg("p2", 8'h34, 26'h48D159, 6'b000111, 64'h0);
        @(posedge clk); #1;

        // Malformed L=0 and L=1 packets
        send_pkt('{mk_hdr(8'd0, 8'h00)});
        @(negedge clk);
        chk("l0_err", err_pulse, 1);
        @(posedge clk); #1;
        send_pkt('{mk_hdr(8'd1, 8'h01), 64'h4000});
        @(negedge clk);
        chk("l1_err", err_pulse, 1);
        chk("l1_no_valid", msg_valid, 0);
        @(negedge clk);
        chk("l1_err_single", err_pulse, 0);
        chk("err_count", msg_count, 2);
        @(posedge clk); #1;
        send_pkt('{mk_hdr(8'd3, 8'hA5), 64'hFF_FFFF_C000, mk_src(8'hFA, 8'h0F),
                   64'h01234567_89ABCDEF});
        expect_msg("p3", 8'hA5, 26'h3FFFFFF, 6'b111010, 64'h01234567_89ABCDEF);
        @(posedge clk); #1;

        // L=6: first data word kept, rest drained
        send_pkt('{mk_hdr(8'd6, 8'h5A), 64'h4000, mk_src(8'd1, 8'd1),
                   64'h11, 64'h22, 64'h33, 64'h44});
        expect_msg("p4", 8'h5A, 26'h1, 6'b001001, 64'h11);
        @(posedge clk); #1;

        // Consumer stalls while the next header is already offered
        msg_ready = 1'b0;
        send_pkt('{mk_hdr(8'd2, 8'h01), 64'h8000, mk_src(8'd3, 8'd4)});
        fork
            send_pkt('{mk_hdr(8'd3, 8'h02), 64'hC000, mk_src(8'd0, 8'd7), 64'h99});
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_ready", flit_ready, 0);
                    chk("stall_valid", msg_valid, 1);
                    chk("stall_type", msg_type, 8'h01);
                    chk("stall_tag", msg_tag, 26'h2);
                    chk("stall_src", msg_source, 6'b100011);
                end
                msg_ready = 1'b1;
            end
        join
        expect_msg("p6", 8'h02, 26'h3, 6'b111000, 64'h99);
        @(negedge clk);
        chk("p6_count", msg_count, 6);
        @(posedge clk); #1;

        // Reset in the middle of a packet
        send_flit(mk_hdr(8'd3, 8'h77));
        send_flit(64'h4_0000);
        flit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_type", msg_type, 0);
        chk("mid_rst_tag", msg_tag, 0);
        chk("mid_rst_count", msg_count, 0);
        @(posedge clk); #1;
        send_pkt('{mk_hdr(8'd3, 8'h66), 64'h4000, mk_src(8'd2, 8'd3), 64'h55});
        expect_msg("p7", 8'h66, 26'h1, 6'b011010, 64'h55);
        @(negedge clk);
        chk("p7_count", msg_count, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
